// File: rtl/fadc_ctrl_avg_pkg.sv
// ---------------------------------------------------------------------------
// fadc_ctrl_avg_pkg
//
// Purpose : shared definitions for the averaging flash-ADC controller.
//           Holds the controller state encoding and the depth of the
//           synchroniser chains used on the PAD/scan inputs.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package fadc_ctrl_avg_pkg;

    // Controller states. The 3-bit encoding leaves room for a future state
    // without changing the state register width.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Number of metastability flops on every asynchronous input. START
    // carries one additional history flop for rising-edge detection.
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/fadc_ctrl_avg_therm2bin.sv
// ---------------------------------------------------------------------------
// fadc_ctrl_avg_therm2bin
//
// Purpose : purely combinational thermometer-to-binary converter for the
//           flash comparator bank. The output code is the index of the
//           highest set comparator bit plus one; all-zeros gives 0.
//
// Configuration macro : FADC_BUBBLE_CORR_EN
//           defined   -> each comparator bit is first replaced by the
//                        majority of itself and its two neighbours, with
//                        the bit below the bank taken as 1 and the bit
//                        above the bank taken as 0. Adds no pipeline stage.
//           undefined -> the raw capture drives the decoder directly.
//
// Ports   :
//   therm_i  in   2^NBITS-1  captured thermometer code, bit0 = lowest threshold
//   code_o   out  NBITS      binary code
// ---------------------------------------------------------------------------
module fadc_ctrl_avg_therm2bin #(
    parameter int NBITS = 3
) (
    input  logic [(2**NBITS)-2:0] therm_i,
    output logic [NBITS-1:0]      code_o
);

    localparam int NCOMP = (2**NBITS) - 1;

    logic [NCOMP-1:0] cleanTherm;

`ifdef FADC_BUBBLE_CORR_EN
    // The padded vector places a forced 1 below bit0 and a forced 0 above
    // the top comparator, so edge bits see a well-defined neighbourhood.
    // A lone 0 inside a run of 1s (or a lone 1 above it) is voted away.
    logic [NCOMP+1:0] paddedTherm;

    always_comb begin
        paddedTherm = {1'b0, therm_i, 1'b1};
        cleanTherm  = '0;
        for (int i = 0; i < NCOMP; i++) begin
            cleanTherm[i] = (paddedTherm[i]   & paddedTherm[i+1]) |
                            (paddedTherm[i]   & paddedTherm[i+2]) |
                            (paddedTherm[i+1] & paddedTherm[i+2]);
        end
    end
`else
    // Without correction the raw capture goes straight to the decoder.
    assign cleanTherm = therm_i;
`endif

    // Priority decode: later iterations overwrite earlier ones, so the
    // highest set bit wins.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < NCOMP; i++) begin
            if (cleanTherm[i]) begin
                code_o = NBITS'(i + 1);
            end
        end
    end

endmodule

// File: rtl/fadc_ctrl_avg.sv
// ---------------------------------------------------------------------------
// fadc_ctrl_avg
//
// Purpose : parametrised flash-ADC digital controller with averaging.
//           On a synchronised rising edge of START it loads the bias code,
//           waits SETTLE_CYC cycles, then strobes and captures the
//           comparator bank 2^NAVG_LOG2 times, accumulates the decoded
//           codes and publishes the truncated average with a VALID pulse.
//
// Configuration macro : FADC_BUBBLE_CORR_EN (consumed by the decoder
//           sub-module; enables majority bubble correction of captures).
//
// Ports   :
//   clk       in   1           system clock, rising edge
//   RSTN      in   1           asynchronous active-low reset
//   START     in   1           unsynchronised conversion request (rising edge)
//   BIAS_SET  in   BIAS_W      unsynchronised bias code from PAD/scan
//   COMP_OUT  in   2^NBITS-1   thermometer code from the comparator bank
//   BIAS_OUT  out  BIAS_W      registered bias code to the flash core
//   COMP_EN   out  1           one-cycle comparator strobe per capture
//   DOUT      out  NBITS       averaged result, held until the next VALID
//   VALID     out  1           one-cycle pulse when DOUT/OVR update
//   BUSY      out  1           high from SETTLE through DONE
//   OVR       out  1           a capture of the last conversion was all-ones
// ---------------------------------------------------------------------------
module fadc_ctrl_avg
    import fadc_ctrl_avg_pkg::*;
#(
    parameter int NBITS      = 3,
    parameter int NAVG_LOG2  = 2,
    parameter int SETTLE_CYC = 4,
    parameter int BIAS_W     = 4
) (
    input  logic                  clk,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic [BIAS_W-1:0]     BIAS_SET,
    input  logic [(2**NBITS)-2:0] COMP_OUT,
    output logic [BIAS_W-1:0]     BIAS_OUT,
    output logic                  COMP_EN,
    output logic [NBITS-1:0]      DOUT,
    output logic                  VALID,
    output logic                  BUSY,
    output logic                  OVR
);

    localparam int NCOMP = (2**NBITS) - 1;
    localparam int ACC_W = NBITS + NAVG_LOG2;
    localparam int CNT_W = NAVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] NSAMP       = CNT_W'(2**NAVG_LOG2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    state_e              state_q;
    logic [SYNC_DEPTH:0] startSync_q;
    logic [BIAS_W-1:0]   biasMeta_q;
    logic [BIAS_W-1:0]   biasSync_q;
    logic [NCOMP-1:0]    compCap_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [SET_W-1:0]    settleCnt_q;
    logic                ovrFlag_q;

    logic                trigger;
    logic                capAllOnes;
    logic [NBITS-1:0]    capCode;

    // Decoder for the latched comparator word.
    fadc_ctrl_avg_therm2bin #(
        .NBITS (NBITS)
    ) u_therm2bin (
        .therm_i (compCap_q),
        .code_o  (capCode)
    );

    // Rising edge of the synchronised START: newest synced bit high while
    // the history flop still holds the previous low level.
    assign trigger    = startSync_q[SYNC_DEPTH-1] & ~startSync_q[SYNC_DEPTH];
    assign capAllOnes = &compCap_q;

    // Running sum and sample count as they will be after this capture.
    // The accumulator is sized for 2^NAVG_LOG2 maximum codes, so the add
    // never wraps.
    always_comb begin
        acc_d = acc_q + ACC_W'(capCode);
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Synchronisers, sequencing FSM, accumulator and all output registers.
    // Outputs are registered and assigned on the transition into the state
    // that owns them, so COMP_EN is high exactly during STROBE and VALID
    // exactly during DONE. COMP_EN and VALID default low every cycle.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            startSync_q <= '0;
            biasMeta_q  <= '0;
            biasSync_q  <= '0;
            compCap_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            settleCnt_q <= '0;
            ovrFlag_q   <= 1'b0;
            BIAS_OUT    <= '0;
            COMP_EN     <= 1'b0;
            DOUT        <= '0;
            VALID       <= 1'b0;
            BUSY        <= 1'b0;
            OVR         <= 1'b0;
        end else begin
            startSync_q <= {startSync_q[SYNC_DEPTH-1:0], START};
            biasMeta_q  <= BIAS_SET;
            biasSync_q  <= biasMeta_q;
            COMP_EN     <= 1'b0;
            VALID       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_q     <= ST_SETTLE;
                        BIAS_OUT    <= biasSync_q;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        settleCnt_q <= '0;
                        ovrFlag_q   <= 1'b0;
                        BUSY        <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (settleCnt_q == SETTLE_LAST) begin
                        state_q <= ST_STROBE;
                        COMP_EN <= 1'b1;
                    end else begin
                        settleCnt_q <= settleCnt_q + SET_W'(1);
                    end
                end

                // The comparators resolve during the strobe cycle; their
                // word is latched at its closing edge.
                ST_STROBE: begin
                    compCap_q <= COMP_OUT;
                    state_q   <= ST_CAPTURE;
                end

                // The OVR port sees the sticky flag including this capture,
                // since the flag register itself updates at the same edge.
                ST_CAPTURE: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (capAllOnes) begin
                        ovrFlag_q <= 1'b1;
                    end
                    if (cnt_d == NSAMP) begin
                        state_q <= ST_DONE;
                        DOUT    <= acc_d[ACC_W-1:NAVG_LOG2];
                        OVR     <= ovrFlag_q | capAllOnes;
                        VALID   <= 1'b1;
                    end else begin
                        state_q <= ST_STROBE;
                        COMP_EN <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    BUSY    <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fadc_ctrl_avg.sv
// ---------------------------------------------------------------------------
// tb_fadc_ctrl_avg
//
// Purpose : self-checking bench for fadc_ctrl_avg with default parameters.
//           Directed conversions (clean, averaging, overrange, bubble, busy
//           retrigger, held START, reset mid-conversion) followed by random
//           conversions, all compared against a behavioural model of the
//           decode and averaging rules.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_fadc_ctrl_avg;

    localparam int NBITS      = 3;
    localparam int NAVG_LOG2  = 2;
    localparam int SETTLE_CYC = 4;
    localparam int BIAS_W     = 4;
    localparam int NCOMP      = (2**NBITS) - 1;
    localparam int NSAMP      = 2**NAVG_LOG2;
    localparam int LATENCY    = 2 + SETTLE_CYC + 2 * NSAMP;
    localparam int WINDOW     = 70;

    logic              clk      = 1'b0;
    logic              RSTN     = 1'b0;
    logic              START    = 1'b0;
    logic [BIAS_W-1:0] BIAS_SET = '0;
    logic [NCOMP-1:0]  COMP_OUT = '0;
    logic [BIAS_W-1:0] BIAS_OUT;
    logic              COMP_EN;
    logic [NBITS-1:0]  DOUT;
    logic              VALID;
    logic              BUSY;
    logic              OVR;

    int testCount = 0;
    int failCount = 0;

    logic [NCOMP-1:0] capList [NSAMP];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    fadc_ctrl_avg #(
        .NBITS      (NBITS),
        .NAVG_LOG2  (NAVG_LOG2),
        .SETTLE_CYC (SETTLE_CYC),
        .BIAS_W     (BIAS_W)
    ) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .START    (START),
        .BIAS_SET (BIAS_SET),
        .COMP_OUT (COMP_OUT),
        .BIAS_OUT (BIAS_OUT),
        .COMP_EN  (COMP_EN),
        .DOUT     (DOUT),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .OVR      (OVR)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference decode: optionally vote each bit with its neighbours (bank
    // padded with 1 below and 0 above), then report the position of the
    // highest comparator that fired, counting from 1.
    function automatic int modelCode(input logic [NCOMP-1:0] therm);
        logic [NCOMP-1:0] bits;
        int               level;
        bits = therm;
`ifdef FADC_BUBBLE_CORR_EN
        for (int i = 0; i < NCOMP; i++) begin
            int below;
            int above;
            below   = (i == 0) ? 1 : int'(therm[i-1]);
            above   = (i == NCOMP - 1) ? 0 : int'(therm[i+1]);
            bits[i] = ((below + int'(therm[i]) + above) >= 2);
        end
`endif
        level = 0;
        for (int i = 0; i < NCOMP; i++) begin
            if (bits[i]) level = i + 1;
        end
        return level;
    endfunction

    // Thermometer word with the lowest n comparators set.
    function automatic logic [NCOMP-1:0] thermOf(input int n);
        logic [NCOMP-1:0] t;
        t = '0;
        for (int j = 0; j < n; j++) t[j] = 1'b1;
        return t;
    endfunction

    // Runs one conversion using capList as the successive comparator words.
    // START rises just before edge E0; the k-th negedge after E0 is sample k.
    task automatic applyStimulus(input string name, input logic [BIAS_W-1:0] bias,
                                 input int holdCycles, input bit glitchAtStrobe);
        int   sum;
        bit   ovrExp;
        int   validCount;
        int   validAt;
        int   pulses;
        bit   dropNext;
        logic [31:0] doutSeen;
        logic [31:0] ovrSeen;

        sum    = 0;
        ovrExp = 1'b0;
        for (int i = 0; i < NSAMP; i++) begin
            sum += modelCode(capList[i]);
            if (capList[i] == {NCOMP{1'b1}}) ovrExp = 1'b1;
        end

        BIAS_SET = bias;
        COMP_OUT = capList[0];
        repeat (4) @(negedge clk);
        START = 1'b1;

        validCount = 0;
        validAt    = -1;
        pulses     = 0;
        dropNext   = 1'b0;
        doutSeen   = '0;
        ovrSeen    = '0;
        for (int k = 0; k < WINDOW; k++) begin
            @(negedge clk);
            if (dropNext) begin
                START    = 1'b0;
                dropNext = 1'b0;
            end
            if (k == holdCycles - 1) START = 1'b0;
            if (k == 1) checkOutput({name, "/busyBeforeSettle"}, BUSY, 0);
            if (k == 2) begin
                checkOutput({name, "/busyInSettle"}, BUSY, 1);
                checkOutput({name, "/biasOut"}, BIAS_OUT, bias);
            end
            if (COMP_EN) begin
                if (pulses < NSAMP) COMP_OUT = capList[pulses];
                if (glitchAtStrobe && pulses == 0) begin
                    START    = 1'b1;
                    dropNext = 1'b1;
                end
                pulses++;
            end
            if (VALID) begin
                validCount++;
                if (validAt < 0) begin
                    validAt  = k;
                    doutSeen = DOUT;
                    ovrSeen  = OVR;
                end
            end
        end

        checkOutput({name, "/validCount"}, validCount, 1);
        checkOutput({name, "/validLatency"}, validAt, LATENCY);
        checkOutput({name, "/compEnPulses"}, pulses, NSAMP);
        checkOutput({name, "/dout"}, doutSeen, sum / NSAMP);
        checkOutput({name, "/ovr"}, ovrSeen, ovrExp);
        checkOutput({name, "/doutHeld"}, DOUT, sum / NSAMP);
        checkOutput({name, "/busyAfter"}, BUSY, 0);
    endtask

    // Starts a conversion and asserts reset while the second sample is in
    // its capture cycle; everything must clear at once and no VALID follow.
    task automatic checkResetMidConversion();
        int pulses;
        int waited;
        int validCount;

        BIAS_SET = 4'hA;
        COMP_OUT = thermOf(4);
        repeat (4) @(negedge clk);
        START  = 1'b1;
        pulses = 0;
        waited = 0;
        while (pulses < 2 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (waited == 2) START = 1'b0;
            if (COMP_EN) pulses++;
        end
        START = 1'b0;
        checkOutput("rst/reachSecondStrobe", pulses, 2);

        @(negedge clk);
        RSTN = 1'b0;
        #1;
        checkOutput("rst/compEn", COMP_EN, 0);
        checkOutput("rst/busy", BUSY, 0);
        checkOutput("rst/dout", DOUT, 0);
        checkOutput("rst/biasOut", BIAS_OUT, 0);
        checkOutput("rst/ovr", OVR, 0);
        repeat (2) @(negedge clk);
        RSTN = 1'b1;

        validCount = 0;
        repeat (30) begin
            @(negedge clk);
            if (VALID) validCount++;
        end
        checkOutput("rst/noValidAfter", validCount, 0);
    endtask

    // Directed scenarios first, then randomized conversions.
    initial begin
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset/compEn", COMP_EN, 0);
        checkOutput("reset/valid", VALID, 0);
        checkOutput("reset/busy", BUSY, 0);
        checkOutput("reset/dout", DOUT, 0);
        checkOutput("reset/ovr", OVR, 0);
        checkOutput("reset/biasOut", BIAS_OUT, 0);
        RSTN = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NSAMP; i++) capList[i] = 7'b0001111;
        applyStimulus("clean", 4'h3, 1, 1'b0);

        capList = '{thermOf(3), thermOf(4), thermOf(4), thermOf(5)};
        applyStimulus("avg3445", 4'h5, 2, 1'b0);

        capList = '{thermOf(7), thermOf(7), thermOf(7), thermOf(6)};
        applyStimulus("ovr7776", 4'hC, 1, 1'b0);

        for (int i = 0; i < NSAMP; i++) capList[i] = 7'b0010111;
        applyStimulus("bubble", 4'hA, 1, 1'b0);

        capList = '{thermOf(2), thermOf(6), thermOf(1), thermOf(0)};
        applyStimulus("busyRetrigger", 4'h1, 1, 1'b1);

        capList = '{thermOf(6), thermOf(6), thermOf(5), thermOf(7)};
        applyStimulus("held50", 4'h6, 50, 1'b0);

        checkResetMidConversion();

        capList = '{thermOf(1), thermOf(2), thermOf(3), thermOf(4)};
        applyStimulus("afterReset", 4'h9, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NSAMP; i++) begin
                logic [NCOMP-1:0] t;
                t = thermOf(int'($urandom_range(0, NCOMP)));
                if ($urandom_range(0, 3) == 0) begin
                    t[$urandom_range(0, NCOMP - 1)] = ~t[$urandom_range(0, NCOMP - 1)];
                end
                capList[i] = t;
            end
            applyStimulus($sformatf("rand%0d", r), BIAS_W'($urandom_range(0, 15)),
                          int'($urandom_range(1, 6)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
